// File: rtl/clock_reset_sequencer_if.sv
// clock_reset_sequencer_if: lock status, divide programming and reset/clock-enable outputs of the sequencer
interface clock_reset_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 16
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic locked;
  logic div_we;
  logic [CH_W-1:0] div_ch;
  logic [DIV_W-1:0] div_val;
  logic lock_lost_clr;
  logic sys_reset;
  logic [NUM_CH-1:0] ce;
  logic lock_lost;
  logic [1:0] seq_state;
  modport master (
    output locked, div_we, div_ch, div_val, lock_lost_clr,
    input sys_reset, ce, lock_lost, seq_state
  );
  modport slave (
    input locked, div_we, div_ch, div_val, lock_lost_clr,
    output sys_reset, ce, lock_lost, seq_state
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer: lock-qualified system reset plus programmable per-channel clock-enable strobes
module clock_reset_sequencer #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 16,
  parameter int DIV_INIT = 1,
  parameter int LOCK_CYCLES = 64,
  parameter int RST_HOLD = 16
) (
  input logic clk,
  input logic reset,
  clock_reset_sequencer_if.slave bus
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
  state_t state, state_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic sync1, locked_s, lock_drop, run_hold;
  logic [NUM_CH-1:0] ce;
  assign lock_drop = state == RUN && !locked_s;
  assign run_hold = state == RUN && state_n == RUN;
  assign bus.seq_state = state;
  assign bus.ce = ce;
  // two-flop synchroniser for the asynchronous lock status
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1 <= bus.locked;
      locked_s <= sync1;
    end
  // sequencer registers; reset output follows the next state so it changes on the RUN entry/exit edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= WAIT_LOCK;
      lock_cnt <= '0;
      hold_cnt <= '0;
      bus.sys_reset <= 1'b1;
      bus.lock_lost <= 1'b0;
    end else begin
      state <= state_n;
      lock_cnt <= lock_cnt_n;
      hold_cnt <= hold_cnt_n;
      bus.sys_reset <= state_n != RUN;
      bus.lock_lost <= lock_drop | (bus.lock_lost & ~bus.lock_lost_clr);
    end
  // next state: any loss of synchronised lock falls straight back to WAIT_LOCK
  always_comb begin
    state_n = state;
    lock_cnt_n = lock_cnt;
    hold_cnt_n = hold_cnt;
    if (!locked_s) begin
      state_n = WAIT_LOCK;
      lock_cnt_n = '0;
      hold_cnt_n = '0;
    end else
      case (state)
        WAIT_LOCK: begin
          state_n = STABLE;
          lock_cnt_n = LW'(1);
        end
        STABLE: begin
          state_n = lock_cnt == LW'(LOCK_CYCLES) ? HOLD : STABLE;
          lock_cnt_n = lock_cnt == LW'(LOCK_CYCLES) ? lock_cnt : lock_cnt + LW'(1);
          hold_cnt_n = '0;
        end
        HOLD: begin
          hold_cnt_n = hold_cnt + HW'(1);
          state_n = hold_cnt + HW'(1) == HW'(RST_HOLD) ? RUN : HOLD;
        end
        default: state_n = RUN;
      endcase
  end
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] div_reg, cnt, last;
      logic wr;
      assign wr = bus.div_we && int'(bus.div_ch) == i;
      assign last = div_reg == '0 ? '0 : div_reg - DIV_W'(1);
      assign ce[i] = state == RUN && cnt == last;
      // divide register and phase counter; the counter only runs while staying in RUN
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          div_reg <= DIV_W'(DIV_INIT);
          cnt <= '0;
        end else begin
          if (wr) div_reg <= bus.div_val;
          cnt <= (wr || !run_hold || cnt == last) ? '0 : cnt + DIV_W'(1);
        end
    end
  endgenerate
endmodule
